// File: rtl/regfile_pkg.sv
// Shared widths and the write-request record for the register-file write arbiter.
// Pure declarations: no latency and no flow control.
package regfile_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back requester bundle: requesters drive valid/rd/data and receive ready.
// Ready is combinational in the same cycle; the requester holds its write until ready.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = ADDR_W,
    parameter int DW      = DATA_W
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_rd;
    logic [NUM_REQ*DW-1:0] req_data;

    modport master (output req_valid, output req_rd, output req_data, input req_ready);
    modport slave  (input req_valid, input req_rd, input req_data, output req_ready);
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant generator: combinational one-hot grant, pointer updates on accept.
// The sink never stalls, so accept is simply "any request valid".
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         accept
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Search starts one past the last accepted index and wraps around.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = idx;
            end
        end
        accept = found;
    end

    // Resetting to the last index gives requester 0 first priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= PTR_W'(N-1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Grants one write-back source per cycle and registers it toward the register file (1-cycle latency).
// No backpressure from the register file; losers simply keep valid asserted. Tracks per-register busy bits.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave req_if,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_rd,
    output logic [ADDR_W-1:0]      rd,
    output logic [DATA_W-1:0]      writeData,
    output logic                   RegWEn,
    output logic [2**ADDR_W-1:0]   busy
);
    import regfile_pkg::*;

    localparam int NREG = 2**ADDR_W;

    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    wr_req_t            win;

    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [NREG-1:0]    busy_q, busy_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req_if.req_valid),
        .gnt    (gnt),
        .accept (accept)
    );

    assign req_if.req_ready = gnt;

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win.valid = 1'b1;
                win.rd    = req_if.req_rd[i*ADDR_W +: ADDR_W];
                win.data  = req_if.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // x0 writes still consume the grant but never strobe the register file.
    always_comb begin
        rd_d    = rd_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (accept) begin
            rd_d    = win.rd;
            wdata_d = win.data;
            we_d    = (win.rd != '0);
        end
    end

    // Clear on commit first so a same-cycle reservation of that register wins.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    assign rd        = rd_q;
    assign writeData = wdata_q;
    assign RegWEn    = we_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued by the stimulus
// and popped by a monitor whenever RegWEn is seen; grants and busy bits are checked inline.
module tb_regfile_write_arbiter;
    logic        clk;
    logic        reset;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic [4:0]  rd;
    logic [31:0] writeData;
    logic        RegWEn;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    regfile_write_arbiter_if #(.NUM_REQ(2), .AW(5), .DW(32)) rif ();

    regfile_write_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_if    (rif.slave),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .rd        (rd),
        .writeData (writeData),
        .RegWEn    (RegWEn),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1);
        rif.req_valid = v;
        rif.req_rd    = {r1, r0};
        rif.req_data  = {d1, d0};
    endtask

    task automatic idle();
        rif.req_valid = 2'b00;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every committed write must match the oldest expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (RegWEn === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write at %0t",
                             rd, writeData, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (rd !== e.rd || writeData !== e.data) begin
                        errors++;
                        $display("FAIL write_data: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h at %0t",
                                 rd, writeData, e.rd, e.data, $time);
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        rsv_valid = 1'b0;
        rsv_rd    = 5'd0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #2;
        chk("reset_regwen", {31'b0, RegWEn}, 32'h0);
        chk("reset_busy", busy, 32'h0);
        chk("reset_ready", {30'b0, rif.req_ready}, 32'h0);
        chk("reset_rd", {27'b0, rd}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // First write after reset
        tick();
        drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        #1 chk("first_ready", {30'b0, rif.req_ready}, 32'h1);
        push(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        chk("first_regwen", {31'b0, RegWEn}, 32'h1);

        // Single write by requester 1 so contention starts with requester 0
        drive(2'b10, 5'd0, 32'h0, 5'd1, 32'h11);
        #1 chk("req1_ready", {30'b0, rif.req_ready}, 32'h2);
        push(5'd1, 32'h11);
        tick();

        // Contention: grants alternate 0,1,0,1
        drive(2'b11, 5'd3, 32'h33330000, 5'd7, 32'h77770000);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("contend_ready", {30'b0, rif.req_ready}, 32'h1);
                push(5'd3, 32'h33330000);
            end else begin
                chk("contend_ready", {30'b0, rif.req_ready}, 32'h2);
                push(5'd7, 32'h77770000);
            end
            tick();
        end

        // Requester 0 alone, leaving ptr at 0
        drive(2'b01, 5'd2, 32'h22, 5'd0, 32'h0);
        #1 chk("req0_ready", {30'b0, rif.req_ready}, 32'h1);
        push(5'd2, 32'h22);
        tick();

        // x0 write by requester 1: granted, no commit, ptr advances
        drive(2'b10, 5'd0, 32'h0, 5'd0, 32'h55);
        #1 chk("x0_ready", {30'b0, rif.req_ready}, 32'h2);
        tick();
        idle();
        chk("x0_regwen", {31'b0, RegWEn}, 32'h0);
        drive(2'b11, 5'd3, 32'h33330000, 5'd7, 32'h77770000);
        #1 chk("after_x0_ready", {30'b0, rif.req_ready}, 32'h1);
        push(5'd3, 32'h33330000);
        tick();
        idle();

        // Scoreboard set, x0 reservation ignored
        rsv_valid = 1'b1;
        rsv_rd    = 5'd9;
        tick();
        rsv_valid = 1'b0;
        chk("busy_set9", busy, 32'h0000_0200);
        rsv_valid = 1'b1;
        rsv_rd    = 5'd0;
        tick();
        rsv_valid = 1'b0;
        chk("busy_rsv_x0", busy, 32'h0000_0200);

        // Write to 9 in cycle N: still busy in N+1, clear in N+2
        drive(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
        #1 chk("w9_ready", {30'b0, rif.req_ready}, 32'h1);
        push(5'd9, 32'h99);
        tick();
        idle();
        chk("busy9_n1", busy, 32'h0000_0200);
        tick();
        chk("busy9_n2", busy, 32'h0);

        // Reserve 9 in the same cycle a write to 9 commits: set wins
        rsv_valid = 1'b1;
        rsv_rd    = 5'd9;
        tick();
        rsv_valid = 1'b0;
        drive(2'b01, 5'd9, 32'h9A, 5'd0, 32'h0);
        push(5'd9, 32'h9A);
        tick();
        idle();
        chk("commit9_regwen", {31'b0, RegWEn}, 32'h1);
        rsv_valid = 1'b1;
        rsv_rd    = 5'd9;
        tick();
        rsv_valid = 1'b0;
        chk("busy9_set_wins", busy, 32'h0000_0200);
        tick();
        chk("busy9_held", busy, 32'h0000_0200);

        // Reset while a write is in flight; ptr left at 0 beforehand
        drive(2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
        #1 chk("w6_ready", {30'b0, rif.req_ready}, 32'h1);
        tick();
        idle();
        chk("inflight_regwen", {31'b0, RegWEn}, 32'h1);
        reset = 1'b0;
        #1;
        chk("midreset_regwen", {31'b0, RegWEn}, 32'h0);
        chk("midreset_busy", busy, 32'h0);
        chk("midreset_rd", {27'b0, rd}, 32'h0);
        chk("midreset_wdata", writeData, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        drive(2'b11, 5'd3, 32'h33330000, 5'd7, 32'h77770000);
        #1 chk("post_reset_ready", {30'b0, rif.req_ready}, 32'h1);
        push(5'd3, 32'h33330000);
        tick();
        idle();
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the RegisterFile write port (rd, writeData, RegWEn) between several write-back sources, such as the ALU write-back path and multi-cycle units like load or divide. It grants one source per cycle with round-robin fairness and registers the winning write toward the register file. It also keeps a per-register busy scoreboard so decode can stall on pending writes.

## Interface
- NUM_REQ, 2, number of write requesters (2..4)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i holds a write
- req_ready  out  NUM_REQ  requester i's write is accepted this cycle
- req_rd  in  NUM_REQ*ADDR_W  destination of requester i, packed slice [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  write data of requester i, packed
- rsv_valid  in  1  decode reserves a destination register
- rsv_rd  in  ADDR_W  register being reserved
- rd  out  ADDR_W  to RegisterFile rd
- writeData  out  DATA_W  to RegisterFile writeData
- RegWEn  out  1  to RegisterFile RegWEn
- busy  out  2**ADDR_W  bit r set means a write to register r is pending

## Operation
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both 1. The requester holds valid, rd and data stable until accepted. At most one req_ready bit is 1 per cycle.
- Grant: round-robin over the valid requesters, starting at the index after the last accepted requester (ptr). Combinational from req_valid and ptr. The register file never back-pressures, so the arbiter grants whenever any request is valid.
- ptr advances to the accepted index only when a transfer occurs. An idle cycle leaves ptr unchanged.
- Output stage: on transfer, rd and writeData load from the winner. RegWEn loads 1 if the winner's rd != 0, else 0. With no transfer, RegWEn loads 0, and rd and writeData hold their values.
- Writes to x0 are accepted: they consume the grant and advance ptr, but never assert RegWEn.
- Scoreboard:
  - rsv_valid with rsv_rd != 0 sets busy[rsv_rd] at the next edge.
  - A committed write (RegWEn=1) clears busy[rd] at the next edge.
  - If set and clear target the same register in the same cycle, set wins.
  - busy[0] is always 0.
- Two requesters targeting the same rd in one cycle: only the winner is granted; the other waits its turn. No merging.

## Timing
- Reset values: rd=0, writeData=0, RegWEn=0, busy=0, ptr such that requester 0 has highest priority.
- req_ready is combinational and valid in the same cycle as req_valid.
- Latency: a write accepted in cycle N appears on rd, writeData and RegWEn during cycle N+1. The register file captures it at the end of N+1.
- Throughput: one write per cycle. The busy bit for that register clears at the end of N+1 and reads 0 in N+2.
- Fairness bound: a continuously valid requester is granted within NUM_REQ cycles.
- Reset asserted mid-operation clears all state immediately, including an in-flight RegWEn. Requests pending at reset must be re-presented afterwards.

## Structure
- Shared package regfile_pkg holds:
  - constants ADDR_W=5, DATA_W=32, NUM_REGS=32
  - typedef wr_req_t: struct of valid, rd, data
- One sub-module: rr_arbiter, a parameterised round-robin grant generator with ptr state, producing a one-hot grant and an accept strobe.
- The output stage and scoreboard live in regfile_write_arbiter.

## Test plan
- Reset, then idle:
  - RegWEn=0, busy=0, req_ready=0.
  - Release reset, then req_valid=01, req_rd0=5, data=0xDEADBEEF: req_ready=01 that cycle; next cycle rd=5, writeData=0xDEADBEEF, RegWEn=1.
- Contention: both requesters valid for 4 cycles (rd 3 and 7) → grants alternate 0,1,0,1; RegWEn=1 each cycle with rd 3,7,3,7.
- x0 write:
  - Requester 1 writes rd=0, data=0x55: req_ready[1]=1, next cycle RegWEn=0.
  - ptr still advances, so requester 0 wins the next contention.
- Scoreboard:
  - rsv_valid with rsv_rd=9: busy[9]=1 next cycle.
  - A write to rd 9 accepted in cycle N: busy[9]=0 in N+2.
  - Reserve 9 in the same cycle RegWEn commits 9: busy[9] stays 1.
- Reset mid-write: assert reset while RegWEn=1 → RegWEn, busy and ptr clear immediately. After release, requester 0 has priority.
